// File: rtl/freq_meter_ctrl.sv
// Measurement sequencer for the BCD frequency-meter datapath (clear, gate, settle, latch).
// Optional display-hold input enabled by defining FREQ_CTRL_HOLD_EN.
module freq_meter_ctrl #(
  parameter int GATE_CYCLES  = 1000,
  parameter int CLEAR_CYCLES = 2,
  parameter int TB_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sig_in,
  input  logic       ovf_in,
`ifdef FREQ_CTRL_HOLD_EN
  input  logic       hold,
`endif
  output logic       cnt_clr_n,
  output logic       cnt_pulse,
  output logic       reg_load,
  output logic       meas_done,
  output logic       overflow,
  output logic [2:0] state_out
);

  // state  | meaning
  // IDLE   | waiting for start, counter chain released
  // CLEAR  | counter chain held in clear for CLEAR_CYCLES
  // GATE   | gate window open, rising edges of sig_in counted
  // SETTLE | one cycle for the final increment to ripple through
  // LATCH  | display load strobe, overflow captured
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    GATE   = 3'd2,
    SETTLE = 3'd3,
    LATCH  = 3'd4
  } state_t;

  localparam logic [TB_W-1:0] CLR_LAST  = TB_W'(CLEAR_CYCLES - 1);
  localparam logic [TB_W-1:0] GATE_LAST = TB_W'(GATE_CYCLES - 1);

  state_t          state, state_nx;
  logic [TB_W-1:0] timebase;
  logic            sig_q;
  logic            ovf_acc;
  logic            edge_det;
  logic            load_en;

`ifdef FREQ_CTRL_HOLD_EN
  assign load_en = ~hold;
`else
  assign load_en = 1'b1;
`endif

  assign edge_det  = sig_in & ~sig_q;
  assign state_out = state;

  always_comb begin
    state_nx  = state;
    cnt_clr_n = 1'b1;
    reg_load  = 1'b0;
    meas_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = CLEAR;
      end
      CLEAR: begin
        cnt_clr_n = 1'b0;
        if (timebase == CLR_LAST) state_nx = GATE;
      end
      GATE: begin
        if (timebase == GATE_LAST) state_nx = SETTLE;
      end
      SETTLE: begin
        state_nx = LATCH;
      end
      LATCH: begin
        reg_load  = load_en;
        meas_done = 1'b1;
        state_nx  = start ? CLEAR : IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset forces the chain into clear and suppresses strobes immediately.
    if (!reset) begin
      cnt_clr_n = 1'b0;
      reg_load  = 1'b0;
      meas_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      timebase  <= '0;
      sig_q     <= 1'b0;
      ovf_acc   <= 1'b0;
      overflow  <= 1'b0;
      cnt_pulse <= 1'b0;
    end else begin
      state     <= state_nx;
      timebase  <= (state_nx != state) ? '0 : timebase + TB_W'(1);
      sig_q     <= sig_in;
      cnt_pulse <= (state == GATE) & edge_det;
      if (state == CLEAR && state_nx == GATE)
        ovf_acc <= 1'b0;
      else if (state == GATE || state == SETTLE)
        ovf_acc <= ovf_acc | ovf_in;
      // Capture includes ovf_in from the SETTLE cycle itself.
      if (state == SETTLE && load_en)
        overflow <= ovf_acc | ovf_in;
    end
  end

endmodule
